fpu_cmd_issuer: RTL

- Sequential front end that drives the combinational single-precision FPU.
- Queues operation commands (A, B, op) arriving on a valid/ready interface, presents each to the FPU operand/op inputs, and waits a fixed settle window so the FPU path can be a multicycle path.
- Captures ALU_output/overflow/underflow and returns them on a valid/ready response interface.
- Sits between the core's FP issue logic and the FPU instance.

---
 rtl/fpu_cmd_issuer.sv | 107 ++++++++++
 1 files changed

// File: rtl/fpu_cmd_issuer.sv
// fpu_cmd_issuer: queues FPU commands, holds operands for a settle window, returns captured results.
// Optional FPU_CMD_ISSUER_STATS_EN adds saturating stat_ops/stat_exc counters.
module fpu_cmd_issuer #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [1:0]  cmd_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_underflow,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_op,
    input  logic [31:0] fpu_result,
    input  logic        fpu_overflow,
    input  logic        fpu_underflow,
    output logic        busy
`ifdef FPU_CMD_ISSUER_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_exc
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

    state_t        state;
    logic [65:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, count;
    logic [CW-1:0] cnt;
    logic          push, pop;

    // pointers carry an extra wrap bit, so count reaches DEPTH exactly when full
    assign count     = wr_ptr - rd_ptr;
    assign cmd_ready = !count[AW];
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state == IDLE && count != '0;
    assign busy      = state != IDLE || count != '0;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            fpu_a         <= '0;
            fpu_b         <= '0;
            fpu_op        <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case (state)
                IDLE: if (pop) begin
                    {fpu_op, fpu_a, fpu_b} <= mem[rd_ptr[AW-1:0]];
                    cnt                    <= CW'(SETTLE_CYCLES - 1);
                    state                  <= ISSUE;
                end
                ISSUE: if (cnt == '0) begin
                    rsp_result    <= fpu_result;
                    rsp_overflow  <= fpu_overflow;
                    rsp_underflow <= fpu_underflow;
                    rsp_valid     <= 1'b1;
                    state         <= RESPOND;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESPOND: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FPU_CMD_ISSUER_STATS_EN
    logic hs;
    assign hs = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops <= '0;
            stat_exc <= '0;
        end else begin
            if (hs && stat_ops != 16'hFFFF) stat_ops <= stat_ops + 1'b1;
            if (hs && (rsp_overflow || rsp_underflow) && stat_exc != 16'hFFFF) stat_exc <= stat_exc + 1'b1;
        end
    end
`endif
endmodule
